// File: rtl/arcade_video_gen.sv
// rtl/arcade_video_gen.sv - pixel timing, fetch and RGB/blank/sync generator for the arcade video front end
//
// Ports:
//   clk_video, reset_n   video clock, asynchronous active-low reset
//   enable               1 = run, 0 = freeze divider, counters and outputs
//   ce_pix               one-clk pixel strobe every CE_DIV enabled clocks
//   fetch_req/x/y        one-clk request for the pixel just entered
//   fetch_data           pixel data, valid FETCH_LAT clocks after fetch_req
//   RGB_out              pixel for the presented position, 0 in blank
//   HBlank/VBlank        blanking flags for the presented position
//   HSync/VSync          active-high sync for the presented position
//   frame_start          one-clk pulse when pixel (0,0) is presented
module arcade_video_gen #(
    parameter int H_ACTIVE  = 320,
    parameter int H_FP      = 8,
    parameter int H_SYNC    = 32,
    parameter int H_BP      = 40,
    parameter int V_ACTIVE  = 240,
    parameter int V_FP      = 4,
    parameter int V_SYNC    = 3,
    parameter int V_BP      = 15,
    parameter int CE_DIV    = 4,
    parameter int DW        = 8,
    parameter int FETCH_LAT = 2
) (
    input  logic          clk_video,
    input  logic          reset_n,
    input  logic          enable,
    output logic          ce_pix,
    output logic          fetch_req,
    output logic [8:0]    fetch_x,
    output logic [8:0]    fetch_y,
    input  logic [DW-1:0] fetch_data,
    output logic [DW-1:0] RGB_out,
    output logic          HBlank,
    output logic          VBlank,
    output logic          HSync,
    output logic          VSync,
    output logic          frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CE_DIV - 1);
    localparam logic [8:0] HA     = 9'(H_ACTIVE);
    localparam logic [8:0] HS_BEG = 9'(H_ACTIVE + H_FP);
    localparam logic [8:0] HS_END = 9'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] VA     = 9'(V_ACTIVE);
    localparam logic [8:0] VS_BEG = 9'(V_ACTIVE + V_FP);
    localparam logic [8:0] VS_END = 9'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);

    logic [DIV_W-1:0]     r_div;
    logic [8:0]           r_hcnt;
    logic [8:0]           r_vcnt;
    logic [DW-1:0]        r_hold;
    logic [FETCH_LAT-1:0] r_lat;
    logic                 r_fetch_pend;

    logic          w_tick;
    logic          w_capture;
    logic          w_pix_active;
    logic          w_fetch_want;
    logic [DW-1:0] w_hold_next;
    logic [8:0]    w_h_next;
    logic [8:0]    w_v_next;

    assign w_tick       = enable && (r_div == DIV_LAST);
    assign w_capture    = r_lat[FETCH_LAT-1];
    assign w_pix_active = (r_hcnt < HA) && (r_vcnt < VA);
    // A ce_pix that lands on a frozen clock still owes its fetch once enable returns.
    assign w_fetch_want = ce_pix || r_fetch_pend;
    // When the capture edge coincides with the next pixel tick, present the fresh data directly.
    assign w_hold_next  = w_capture ? fetch_data : r_hold;
    assign w_h_next     = (r_hcnt == H_LAST) ? 9'd0 : r_hcnt + 9'd1;
    assign w_v_next     = (r_hcnt != H_LAST) ? r_vcnt :
                          (r_vcnt == V_LAST) ? 9'd0 : r_vcnt + 9'd1;

    always_ff @(posedge clk_video or negedge reset_n) begin
        if (!reset_n) begin
            r_div        <= '0;
            r_hcnt       <= H_LAST;
            r_vcnt       <= V_LAST;
            r_hold       <= '0;
            r_lat        <= '0;
            r_fetch_pend <= 1'b0;
            ce_pix       <= 1'b0;
            fetch_req    <= 1'b0;
            fetch_x      <= 9'd0;
            fetch_y      <= 9'd0;
            RGB_out      <= '0;
            HBlank       <= 1'b1;
            VBlank       <= 1'b1;
            HSync        <= 1'b0;
            VSync        <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            // The fetch latency is fixed in clocks on the source side, so it runs through freezes.
            r_lat[0] <= fetch_req;
            for (int i = 1; i < FETCH_LAT; i++) begin
                r_lat[i] <= r_lat[i-1];
            end
            r_hold <= w_hold_next;

            if (enable) begin
                r_div        <= (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
                r_fetch_pend <= 1'b0;
                fetch_req    <= w_fetch_want && w_pix_active;
                if (w_fetch_want && w_pix_active) begin
                    fetch_x <= r_hcnt;
                    fetch_y <= r_vcnt;
                end
            end else begin
                fetch_req    <= 1'b0;
                r_fetch_pend <= w_fetch_want;
            end

            ce_pix      <= w_tick;
            frame_start <= w_tick && (r_hcnt == 9'd0) && (r_vcnt == 9'd0);

            if (w_tick) begin
                r_hcnt  <= w_h_next;
                r_vcnt  <= w_v_next;
                // Outputs describe the position being left, one pixel behind the counters.
                HBlank  <= (r_hcnt >= HA);
                HSync   <= (r_hcnt >= HS_BEG) && (r_hcnt < HS_END);
                VBlank  <= (r_vcnt >= VA);
                RGB_out <= ((r_hcnt < HA) && (r_vcnt < VA)) ? w_hold_next : '0;
                // VSync moves only with the HSync rising edge.
                if (r_hcnt == HS_BEG) begin
                    VSync <= (r_vcnt >= VS_BEG) && (r_vcnt < VS_END);
                end
            end
        end
    end
endmodule

// File: tb/tb_arcade_video_gen.sv
// tb/tb_arcade_video_gen.sv - scoreboard bench for arcade_video_gen at two divider/latency settings
module tb_arcade_video_gen;
    localparam int HA  = 20;
    localparam int HFP = 2;
    localparam int HSY = 3;
    localparam int HBP = 3;
    localparam int VA  = 6;
    localparam int VFP = 1;
    localparam int VSY = 2;
    localparam int VBP = 1;
    localparam int HT  = HA + HFP + HSY + HBP;
    localparam int VT  = VA + VFP + VSY + VBP;

    logic clk;
    logic reset_n;
    logic en_a;

    logic       ce [2];
    logic       frq[2];
    logic [8:0] fx [2];
    logic [8:0] fy [2];
    logic [7:0] fd [2];
    logic [7:0] rgb[2];
    logic       hb [2];
    logic       vb [2];
    logic       hs [2];
    logic       vs [2];
    logic       fs [2];

    int n_vec = 0;
    int n_bad = 0;

    logic [25:0] sbq [2][$];
    logic [18:0] pipe[2][4];
    logic [29:0] snap[2];
    int     hp[2], vp[2], en_last[2], en_edges[2], dis_cnt[2], req_cnt[2], ce_cnt[2], fs_tot[2];
    bit     started[2], have_fs[2], vs_exp[2], prev_hs[2], prev_vs[2];
    longint fs_cyc[2];
    longint cyc = 0;

    arcade_video_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CE_DIV(4), .DW(8), .FETCH_LAT(2)
    ) u_dut_a (
        .clk_video(clk), .reset_n(reset_n), .enable(en_a),
        .ce_pix(ce[0]), .fetch_req(frq[0]), .fetch_x(fx[0]), .fetch_y(fy[0]),
        .fetch_data(fd[0]), .RGB_out(rgb[0]), .HBlank(hb[0]), .VBlank(vb[0]),
        .HSync(hs[0]), .VSync(vs[0]), .frame_start(fs[0])
    );

    arcade_video_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .CE_DIV(3), .DW(8), .FETCH_LAT(1)
    ) u_dut_b (
        .clk_video(clk), .reset_n(reset_n), .enable(1'b1),
        .ce_pix(ce[1]), .fetch_req(frq[1]), .fetch_x(fx[1]), .fetch_y(fy[1]),
        .fetch_data(fd[1]), .RGB_out(rgb[1]), .HBlank(hb[1]), .VBlank(vb[1]),
        .HSync(hs[1]), .VSync(vs[1]), .frame_start(fs[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] model(input logic [8:0] x, input logic [8:0] y);
        return {x[4:0], y[2:0]};
    endfunction

    task automatic chk(input bit ok, input string name, input int k, input longint act, input longint exp);
        n_vec++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, k, act, exp, $time);
        end
    endtask

    task automatic check_reset();
        for (int k = 0; k < 2; k++) begin
            chk({ce[k], frq[k], fs[k], hs[k], vs[k]} == 5'b0, "rst_strobes", k,
                {ce[k], frq[k], fs[k], hs[k], vs[k]}, 0);
            chk({hb[k], vb[k]} == 2'b11, "rst_blank", k, {hb[k], vb[k]}, 3);
            chk({rgb[k], fx[k], fy[k]} == 26'd0, "rst_data", k, {rgb[k], fx[k], fy[k]}, 0);
        end
    endtask

    // Responder (fixed-latency pixel source) and monitor/scoreboard, both sampled on the falling edge.
    always @(negedge clk) begin
        cyc++;
        for (int k = 0; k < 2; k++) begin
            int lat;
            int cdiv;
            bit act;
            logic [25:0] e;
            lat  = (k == 0) ? 2 : 1;
            cdiv = (k == 0) ? 4 : 3;
            if (!reset_n) begin
                sbq[k].delete();
                for (int i = 0; i < 4; i++) pipe[k][i] = '0;
                fd[k]       = 8'h00;
                en_last[k]  = 2;
                en_edges[k] = 0;
                dis_cnt[k]  = 0;
                req_cnt[k]  = 0;
                ce_cnt[k]   = 0;
                started[k]  = 0;
                have_fs[k]  = 0;
                vs_exp[k]   = 0;
                prev_hs[k]  = 0;
                prev_vs[k]  = 0;
            end else begin
                for (int i = 3; i > 0; i--) pipe[k][i] = pipe[k][i-1];
                pipe[k][0] = {frq[k], fx[k], fy[k]};
                if (frq[k]) begin
                    sbq[k].push_back({fx[k], fy[k], model(fx[k], fy[k])});
                    req_cnt[k]++;
                end
                if (pipe[k][lat][18])
                    fd[k] = model(pipe[k][lat][17:9], pipe[k][lat][8:0]);
                else
                    fd[k] = (sbq[k].size() > 0) ? ~sbq[k][$][7:0] : 8'h5A;

                if (en_last[k] == 1) en_edges[k]++;
                if (en_last[k] == 0) begin
                    dis_cnt[k]++;
                    chk(!ce[k] && !frq[k], "freeze_strobe", k, {ce[k], frq[k]}, 0);
                    chk(snap[k] == {hb[k], vb[k], hs[k], vs[k], rgb[k], fx[k], fy[k]}, "freeze_hold", k,
                        {hb[k], vb[k], hs[k], vs[k], rgb[k], fx[k], fy[k]}, snap[k]);
                end

                if (ce[k]) begin
                    chk(en_edges[k] == cdiv, "ce_period", k, en_edges[k], cdiv);
                    en_edges[k] = 0;
                    ce_cnt[k]++;
                    if (!started[k]) begin
                        hp[k] = HT - 1;
                        vp[k] = VT - 1;
                        started[k] = 1;
                    end else begin
                        hp[k] = (hp[k] == HT - 1) ? 0 : hp[k] + 1;
                        if (hp[k] == 0) vp[k] = (vp[k] == VT - 1) ? 0 : vp[k] + 1;
                    end
                    if (hp[k] == HA + HFP) vs_exp[k] = (vp[k] >= VA + VFP) && (vp[k] < VA + VFP + VSY);
                    begin
                        bit ehb, evb, ehs, efs;
                        ehb = (hp[k] >= HA);
                        evb = (vp[k] >= VA);
                        ehs = (hp[k] >= HA + HFP) && (hp[k] < HA + HFP + HSY);
                        efs = (hp[k] == 0) && (vp[k] == 0);
                        chk({hb[k], vb[k], hs[k], vs[k], fs[k]} == {ehb, evb, ehs, vs_exp[k], efs}, "timing_flags", k,
                            {hb[k], vb[k], hs[k], vs[k], fs[k]}, {ehb, evb, ehs, vs_exp[k], efs});
                    end
                    if (vs[k] != prev_vs[k])
                        chk(hs[k] && !prev_hs[k], "vsync_edge", k, {prev_hs[k], hs[k]}, 1);
                    prev_hs[k] = hs[k];
                    prev_vs[k] = vs[k];
                    act = (hp[k] < HA) && (vp[k] < VA);
                    if (act) begin
                        if (sbq[k].size() == 0) begin
                            chk(0, "scoreboard_empty", k, hp[k], vp[k]);
                        end else begin
                            e = sbq[k].pop_front();
                            chk(e == {9'(hp[k]), 9'(vp[k]), rgb[k]}, "pixel", k,
                                {9'(hp[k]), 9'(vp[k]), rgb[k]}, e);
                        end
                        if (hp[k] == 17 && vp[k] == 5) chk(rgb[k] == 8'h8D, "pixel_17_5", k, rgb[k], 8'h8D);
                    end else begin
                        chk(rgb[k] == 8'h00, "blank_rgb", k, rgb[k], 0);
                    end
                    if (fs[k]) begin
                        if (!have_fs[k]) begin
                            chk(ce_cnt[k] == 2, "first_frame_start", k, ce_cnt[k], 2);
                        end else begin
                            chk(cyc - fs_cyc[k] == longint'(HT * VT * cdiv + dis_cnt[k]), "frame_period", k,
                                cyc - fs_cyc[k], HT * VT * cdiv + dis_cnt[k]);
                            chk(req_cnt[k] == HA * VA, "fetch_count", k, req_cnt[k], HA * VA);
                        end
                        have_fs[k] = 1;
                        fs_cyc[k]  = cyc;
                        dis_cnt[k] = 0;
                        req_cnt[k] = 0;
                        fs_tot[k]++;
                    end
                end
                snap[k]    = {hb[k], vb[k], hs[k], vs[k], rgb[k], fx[k], fy[k]};
                en_last[k] = (k == 0) ? int'(en_a) : 1;
            end
        end
    end

    initial begin
        bit found;
        fs_tot[0] = 0;
        fs_tot[1] = 0;
        reset_n = 1'b0;
        en_a    = 1'b1;
        repeat (3) @(posedge clk);
        #1 check_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2600) @(posedge clk);

        // Freeze dut0 for 100 clocks partway through an active line.
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            found = (hp[0] == 10) && (vp[0] == 2);
        end
        if (!found) begin
            for (int i = 0; i < 1200 && !found; i++) begin
                @(posedge clk);
                found = (hp[0] == 10) && (vp[0] == 2);
            end
        end
        chk(found, "freeze_align", 0, hp[0], 10);
        #2 en_a = 1'b0;
        repeat (100) @(posedge clk);
        #2 en_a = 1'b1;
        repeat (2600) @(posedge clk);

        // Asynchronous reset between clock edges, mid-line.
        @(posedge clk);
        #3 reset_n = 1'b0;
        #1 check_reset();
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (2600) @(posedge clk);

        chk(fs_tot[0] >= 6, "frame_start_seen", 0, fs_tot[0], 6);
        chk(fs_tot[1] >= 8, "frame_start_seen", 1, fs_tot[1], 8);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
